// File: rtl/score_pkg.sv
// Shared definitions for the BCD score engine.
//   DIGITS_DEF      default score width in BCD digits
//   PTS_0..PTS_4    base points (packed BCD) for 0..4 cleared lines
//   state_t         engine FSM states
//   base_points()   line count -> base points; counts above 4 score as 4
package score_pkg;

  localparam int DIGITS_DEF = 4;

  localparam logic [7:0] PTS_0 = 8'h01;
  localparam logic [7:0] PTS_1 = 8'h04;
  localparam logic [7:0] PTS_2 = 8'h09;
  localparam logic [7:0] PTS_3 = 8'h16;
  localparam logic [7:0] PTS_4 = 8'h25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_LINES,
    ST_DONE
  } state_t;

  function automatic logic [7:0] base_points(input logic [2:0] lines);
    logic [7:0] pts;
    case (lines)
      3'd0:    pts = PTS_0;
      3'd1:    pts = PTS_1;
      3'd2:    pts = PTS_2;
      3'd3:    pts = PTS_3;
      default: pts = PTS_4;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder.
//   a, b  : BCD digits (0..9)
//   cin   : carry from the next lower digit
//   sum   : BCD result digit
//   cout  : decimal carry into the next higher digit
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    sum  = raw[3:0];
    cout = 1'b0;
    // Binary sums 10..19 skip the six unused codes to land on a valid digit.
    if (raw > 5'd9) begin
      sum  = 4'(raw + 5'd6);
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_score_engine.sv
// Digit-serial BCD score engine. Each accepted line-clear event adds its base
// points once per current level, one digit per cycle, then updates the line
// accumulator and level, and finally refreshes the high score.
//   clk, rst_n  : clock, synchronous active-low reset
//   hit         : event request, taken only while ready=1
//   line_count  : lines cleared by the event (values above 4 count as 4)
//   clear       : new game; high_score is kept
//   ready       : idle, next hit accepted
//   done        : one-cycle pulse as an event retires
//   score       : packed BCD score, digit 0 least significant
//   high_score  : packed BCD best score since reset
//   level       : binary level 1..MAX_LEVEL
//   overflow    : score saturated at all nines since last clear/reset
//
// state    | meaning
// ST_IDLE  | waiting for hit
// ST_ADD   | adding one points digit per cycle, one pass per level
// ST_LINES | line accumulator and level update
// ST_DONE  | high score update, done pulse
module bcd_score_engine
  import score_pkg::*;
#(
  parameter int DIGITS          = DIGITS_DEF,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hit,
  input  logic [2:0]            line_count,
  input  logic                  clear,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high_score,
  output logic [3:0]            level,
  output logic                  overflow
);

  localparam int W  = 4 * DIGITS;
  localparam int DW = $clog2(DIGITS);

  state_t          state_q, state_d;
  logic [DW-1:0]   dig_q;
  logic [3:0]      rep_q;
  logic            carry_q;
  logic [W-1:0]    pts_q;
  logic [2:0]      lines_q;
  logic [3:0]      acc_q;
  logic [3:0]      level_q;
  logic [W-1:0]    score_q;
  logic [W-1:0]    high_q;
  logic            ovf_q;

  logic [DW+1:0]   bit_base;
  logic [3:0]      add_sum;
  logic            add_cout;
  logic            last_dig;
  logic [2:0]      lines_clamped;
  logic [4:0]      line_sum;

  assign bit_base      = {dig_q, 2'b00};
  assign last_dig      = (dig_q == DW'(DIGITS - 1));
  assign lines_clamped = (line_count > 3'd4) ? 3'd4 : line_count;
  assign line_sum      = {1'b0, acc_q} + {2'b00, lines_q};

  bcd_digit_add u_digit_add (
    .a    (score_q[bit_base +: 4]),
    .b    (pts_q[bit_base +: 4]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clear) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hit) state_d = ST_ADD;
      // Carry out of the MSD ends the event early: saturation.
      ST_ADD:   if (last_dig && (add_cout || rep_q == 4'd1)) state_d = ST_LINES;
      ST_LINES: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_q   <= '0;
      rep_q   <= '0;
      carry_q <= 1'b0;
      pts_q   <= '0;
      lines_q <= '0;
      acc_q   <= '0;
      level_q <= 4'd1;
      score_q <= '0;
      high_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      dig_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      level_q <= 4'd1;
      score_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            pts_q   <= W'(base_points(lines_clamped));
            lines_q <= lines_clamped;
            rep_q   <= level_q;
            dig_q   <= '0;
            carry_q <= 1'b0;
          end
        end
        ST_ADD: begin
          score_q[bit_base +: 4] <= add_sum;
          if (last_dig) begin
            dig_q   <= '0;
            carry_q <= 1'b0;
            if (add_cout) begin
              score_q <= {DIGITS{4'h9}};
              ovf_q   <= 1'b1;
            end else begin
              rep_q <= rep_q - 4'd1;
            end
          end else begin
            dig_q   <= dig_q + DW'(1);
            carry_q <= add_cout;
          end
        end
        ST_LINES: begin
          if (line_sum >= 5'(LINES_PER_LEVEL)) begin
            acc_q <= 4'(line_sum - 5'(LINES_PER_LEVEL));
            if (level_q < 4'(MAX_LEVEL)) level_q <= level_q + 4'd1;
          end else begin
            acc_q <= line_sum[3:0];
          end
        end
        ST_DONE: begin
          if (score_q > high_q) high_q <= score_q;
        end
        default: ;
      endcase
    end
  end

  assign ready      = (state_q == ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign score      = score_q;
  assign high_score = high_q;
  assign level      = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_bcd_score_engine.sv
// Directed bench for bcd_score_engine at default parameters (4 digits,
// 10 lines per level, max level 9).
module tb_bcd_score_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hit = 1'b0;
  logic [2:0]  line_count = 3'd0;
  logic        clear = 1'b0;
  logic        ready, done, overflow;
  logic [15:0] score, high_score;
  logic [3:0]  level;

  int checks = 0;
  int errors = 0;

  int m_score, m_level, m_acc, m_high;
  bit m_ovf;

  always #5 clk = ~clk;

  bcd_score_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hit        (hit),
    .line_count (line_count),
    .clear      (clear),
    .ready      (ready),
    .done       (done),
    .score      (score),
    .high_score (high_score),
    .level      (level),
    .overflow   (overflow)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: decimal score, saturating at 9999, reports expected latency.
  task automatic model_event(input int lc, output int lat);
    int pts, reps;
    int tbl[5] = '{1, 4, 9, 16, 25};
    if (lc > 4) lc = 4;
    pts  = tbl[lc];
    reps = m_level;
    for (int r = 1; r <= m_level; r++) begin
      if (m_score + pts > 9999) begin
        m_score = 9999;
        m_ovf   = 1'b1;
        reps    = r;
        break;
      end
      m_score = m_score + pts;
    end
    lat = 4 * reps + 2;
    m_acc = m_acc + lc;
    if (m_acc >= 10) begin
      m_acc = m_acc - 10;
      if (m_level < 9) m_level = m_level + 1;
    end
    if (m_score > m_high) m_high = m_score;
  endtask

  // Counts falling edges after the accepting edge until done is seen; 0 = timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_event(input logic [2:0] lc, output int lat);
    @(negedge clk);
    hit = 1'b1;
    line_count = lc;
    @(posedge clk);
    #1 hit = 1'b0;
    wait_done(lat);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL reset_score: got %h expected 0000", score); end
    checks++; if (high_score !== 16'h0000) begin errors++; $display("FAIL reset_high: got %h expected 0000", high_score); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL reset_level: got %0d expected 1", level); end
    checks++; if ({ready, done, overflow} !== 3'b100) begin errors++; $display("FAIL reset_flags: got rdy/done/ovf %b expected 100", {ready, done, overflow}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int lat;
    run_event(3'd1, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL single_latency: got %0d expected 6", lat); end
    checks++; if (score !== 16'h0004) begin errors++; $display("FAIL single_score: got %h expected 0004", score); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d expected 1", level); end
    @(posedge clk); #1;
    checks++; if (high_score !== 16'h0004) begin errors++; $display("FAIL single_high: got %h expected 0004", high_score); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", ready); end
  endtask

  task automatic test_levels();
    int lat;
    logic [15:0] exp_s[3] = '{16'h0025, 16'h0050, 16'h0075};
    do_clear();
    checks++; if (score !== 16'h0000 || level !== 4'd1) begin errors++; $display("FAIL lv_clear: got score %h level %0d expected 0000 1", score, level); end
    checks++; if (high_score !== 16'h0004) begin errors++; $display("FAIL lv_clear_high: got %h expected 0004", high_score); end
    for (int i = 0; i < 3; i++) begin
      run_event(3'd4, lat);
      checks++; if (lat !== 6) begin errors++; $display("FAIL lv_latency%0d: got %0d expected 6", i, lat); end
      checks++; if (score !== exp_s[i]) begin errors++; $display("FAIL lv_score%0d: got %h expected %h", i, score, exp_s[i]); end
    end
    checks++; if (level !== 4'd2) begin errors++; $display("FAIL lv_level_up: got %0d expected 2", level); end
    run_event(3'd2, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL lv_x2_latency: got %0d expected 10", lat); end
    checks++; if (score !== 16'h0093) begin errors++; $display("FAIL lv_x2_score: got %h expected 0093", score); end
    checks++; if (level !== 4'd2) begin errors++; $display("FAIL lv_x2_level: got %0d expected 2", level); end
  endtask

  task automatic test_ignored();
    int lat;
    bit bad;
    // 0 lines at level 2: +2. A second hit during ADD must be dropped.
    @(negedge clk);
    hit = 1'b1; line_count = 3'd0;
    @(posedge clk);
    #1 hit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    hit = 1'b1; line_count = 3'd4;
    @(posedge clk);
    #1 hit = 1'b0;
    wait_done(lat);
    checks++; if (lat == 0) begin errors++; $display("FAIL busy_done: got timeout expected done pulse"); end
    checks++; if (score !== 16'h0095) begin errors++; $display("FAIL busy_score: got %h expected 0095", score); end
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || score !== 16'h0095) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL busy_no_queue: got extra event, score %h expected 0095", score); end
    checks++; if (high_score !== 16'h0095) begin errors++; $display("FAIL busy_high: got %h expected 0095", high_score); end
    // hit together with clear: clear wins, hit dropped.
    @(negedge clk);
    hit = 1'b1; clear = 1'b1; line_count = 3'd4;
    @(posedge clk);
    #1 begin hit = 1'b0; clear = 1'b0; end
    checks++; if (score !== 16'h0000 || level !== 4'd1 || overflow !== 1'b0) begin errors++; $display("FAIL hitclr_state: got score %h level %0d ovf %b expected 0000 1 0", score, level, overflow); end
    checks++; if (high_score !== 16'h0095) begin errors++; $display("FAIL hitclr_high: got %h expected 0095", high_score); end
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || ready !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL hitclr_idle: got busy or done, expected idle"); end
  endtask

  task automatic test_clear_mid();
    bit bad;
    @(negedge clk);
    hit = 1'b1; line_count = 3'd4;
    @(posedge clk);
    #1 hit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL clrmid_score: got %h expected 0000", score); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clrmid_ready: got %b expected 1", ready); end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || score !== 16'h0000) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL clrmid_no_done: got done or score change, expected none"); end
  endtask

  task automatic test_saturate();
    int lat, exp_lat, extra;
    do_clear();
    m_score = 0; m_level = 1; m_acc = 0; m_ovf = 1'b0; m_high = 95;
    extra = 0;
    for (int e = 0; e < 100 && extra < 4; e++) begin
      model_event(4, exp_lat);
      run_event(3'd4, lat);
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL sat_latency ev%0d: got %0d expected %0d", e, lat, exp_lat); end
      checks++; if (score !== to_bcd(m_score)) begin errors++; $display("FAIL sat_score ev%0d: got %h expected %h", e, score, to_bcd(m_score)); end
      checks++; if (level !== 4'(m_level)) begin errors++; $display("FAIL sat_level ev%0d: got %0d expected %0d", e, level, m_level); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL sat_ovf ev%0d: got %b expected %b", e, overflow, m_ovf); end
      @(posedge clk); #1;
      checks++; if (high_score !== to_bcd(m_high)) begin errors++; $display("FAIL sat_high ev%0d: got %h expected %h", e, high_score, to_bcd(m_high)); end
      if (m_ovf) extra++;
    end
    checks++; if (extra != 4 || score !== 16'h9999) begin errors++; $display("FAIL sat_reached: got score %h expected 9999", score); end
    checks++; if (level !== 4'd9) begin errors++; $display("FAIL sat_max_level: got %0d expected 9", level); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    hit = 1'b1; line_count = 3'd1;
    @(posedge clk);
    #1 hit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (score !== 16'h0000 || high_score !== 16'h0000) begin errors++; $display("FAIL rstmid_scores: got %h/%h expected 0000/0000", score, high_score); end
    checks++; if (level !== 4'd1 || overflow !== 1'b0) begin errors++; $display("FAIL rstmid_level_ovf: got %0d/%b expected 1/0", level, overflow); end
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got rdy %b done %b expected 1 0", ready, done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_levels();
    test_ignored();
    test_clear_mid();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
